mmio_controller: RTL and testbench
==================================

# mmio_controller

Memory-mapped I/O stage for the 2-stage pipelined processor, sitting directly downstream of the pipeline register in the memory stage, alongside the data memory. It decodes the buffered store and load address, owns the HEX/LEDR/LEDG output registers, and synchronizes and debounces the raw KEY and SW inputs. It also captures change events in sticky status registers so software can poll them.

## Interface
- DBITS, 32, data/address width
- ADDR_HEX, 32'hF0000000, HEX data register (16 bits)
- ADDR_LEDR, 32'hF0000004, LEDR data register (10 bits)
- ADDR_LEDG, 32'hF0000008, LEDG data register (8 bits)
- ADDR_KEY, 32'hF0000010, debounced KEY data (read-only)
- ADDR_SW, 32'hF0000014, debounced SW data (read-only)
- ADDR_KCTRL, 32'hF0000110, KEY status: bit0 ready, bit2 overrun
- ADDR_SCTRL, 32'hF0000114, SW status: bit0 ready, bit2 overrun
- DEB_CYCLES, 50000, debounce stability count (bench uses 4)

Ports:
- clk  in  1  processor clock
- reset  in  1  asynchronous, active-low reset (0 = reset asserted)
- addr  in  DBITS  memory-stage address (dmemAddr_out)
- wrtEn  in  1  store enable (dmemWrtEn_out)
- rdEn  in  1  load in memory stage (memtoReg_out)
- dIn  in  DBITS  store data
- key  in  4  raw push-buttons, active-low
- sw  in  10  raw slide switches
- dOut  out  DBITS  read data, zero-extended
- isIO  out  1  addr matches one of the seven mapped addresses
- hex  out  16  HEX register
- ledr  out  10  LEDR register
- ledg  out  8  LEDG register

## Operation
- Decode: full 32-bit equality compare against each address. isIO=1 only on an exact match. Unaligned or unmapped addresses give isIO=0 and dOut=0.
- Writes, on posedge clk when wrtEn=1:
  - ADDR_HEX: hex<=dIn[15:0].
  - ADDR_LEDR: ledr<=dIn[9:0].
  - ADDR_LEDG: ledg<=dIn[7:0].
  - Writes to ADDR_KEY and ADDR_SW are ignored.
- Reads, combinational from addr regardless of rdEn:
  - Output registers, debounced data, or status are returned zero-extended.
  - Status format is {29'b0, overrun, 1'b0, ready}.
- Input path, per group (KEY 4 bits, SW 10 bits):
  - 2-flop synchronizer. KEY is inverted before the synchronizer, so internal 1 = pressed.
  - One stability counter per group. The counter clears when the synchronized vector differs from its previous-cycle sample; otherwise it increments, saturating at DEB_CYCLES.
  - When counter==DEB_CYCLES and the synchronized vector differs from the debounced vector, the debounced vector is loaded.
- Status, per group:
  - A debounced-vector update sets ready. If ready was already 1, overrun is also set.
  - Load of the data register (rdEn=1, addr=ADDR_KEY or ADDR_SW) clears ready at the next edge.
  - Store to the status address with dIn[0]=0 clears ready; dIn[2]=0 clears overrun. Bits written as 1 are unchanged.
  - Simultaneous update and clear (by read or write) in the same cycle: ready ends at 1 and overrun is unchanged by the clear. The update wins.
- Reset (reset=0), asynchronous:
  - hex=0, ledr=0, ledg=0.
  - Synchronizer and debounced vectors=0; KEY sync flops hold "not pressed".
  - Counters=0; ready=0 and overrun=0.
  - dOut and isIO follow addr combinationally even during reset.
- A switch held high through reset is seen as a change after release: debounced SW becomes 1 and ready sets, after the latency below.

## Timing
- Write-to-output latency: 1 cycle. hex/ledr/ledg show the new value after the edge on which wrtEn was sampled.
- Read latency: 0 cycles (combinational), matching the data memory read timing in the memory stage.
- Raw input change to debounced update: 2 sync cycles + DEB_CYCLES + 1 cycles, if the input is stable throughout. Any glitch restarts the count.
- Status clear takes effect at the edge ending the load/store cycle. A read in the same cycle still returns ready=1.
- Reset assertion mid-debounce discards the pending count. Reset deassertion is synchronous to the first subsequent edge.

## Test plan
- Write: store 0x0000ABCD to ADDR_HEX, 0x3FF to ADDR_LEDR, 0x5A to ADDR_LEDG -> next cycle hex=16'hABCD, ledr=10'h3FF, ledg=8'h5A. Store 0xFFFFFFFF to ADDR_KEY -> no register changes.
- Debounce (DEB_CYCLES=4): key[1] driven 0 and held -> KEY reads 4'b0010 exactly 7 cycles later, and KCTRL reads 1. A 3-cycle pulse on key[1] -> KEY stays 0 and ready stays 0.
- Overrun: two debounced SW changes with no intervening read -> SCTRL=0x5. Load ADDR_SW -> SCTRL=0x4. Store 0 to ADDR_SCTRL -> SCTRL=0x0.
- Collision: debounced KEY update on the same cycle as a load of ADDR_KEY while ready=1 -> KCTRL=0x5 afterwards. Same collision with ready=0 -> KCTRL=0x1.
- Decode: addr 0xF0000012 and 0x00000010 -> isIO=0, dOut=0. Addr ADDR_LEDG after a store -> isIO=1, dOut=0x0000005A.
- Reset: assert reset mid-debounce with ledr=0x3FF -> ledr=0 immediately, counters clear. After release, the held input re-debounces with the full 7-cycle latency.

Source files
------------

// File: rtl/mmio_controller.sv
// mmio_controller: memory-stage MMIO decode, HEX/LED output registers,
// and synchronized, debounced KEY/SW inputs with sticky status.
module mmio_debounce #(
  parameter int W          = 4,
  parameter int DEB_CYCLES = 50000
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] raw,
  input  logic         rdClr,
  input  logic         wrClrRdy,
  input  logic         wrClrOv,
  output logic [W-1:0] deb,
  output logic         ready,
  output logic         overrun
);
  localparam int CW = $clog2(DEB_CYCLES + 1);
  localparam logic [CW-1:0] CMAX = CW'(DEB_CYCLES);

  logic [W-1:0]  s1;
  logic [W-1:0]  s2;
  logic [CW-1:0] cnt;
  logic          upd;

  assign upd = (cnt == CMAX) && (s2 != deb);

  // synchronize, count stable samples, load the debounced vector
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1  <= '0;
      s2  <= '0;
      cnt <= '0;
      deb <= '0;
    end else begin
      s1 <= raw;
      s2 <= s1;
      if (s1 != s2)
        cnt <= '0;
      else if (cnt != CMAX)
        cnt <= cnt + 1'b1;
      if (upd)
        deb <= s2;
    end
  end

  // sticky status; an update in the same cycle beats any clear
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ready   <= 1'b0;
      overrun <= 1'b0;
    end else if (upd) begin
      ready   <= 1'b1;
      overrun <= overrun | ready;
    end else begin
      if (rdClr || wrClrRdy)
        ready <= 1'b0;
      if (wrClrOv)
        overrun <= 1'b0;
    end
  end
endmodule

module mmio_controller #(
  parameter int               DBITS      = 32,
  parameter logic [DBITS-1:0] ADDR_HEX   = 32'hF0000000,
  parameter logic [DBITS-1:0] ADDR_LEDR  = 32'hF0000004,
  parameter logic [DBITS-1:0] ADDR_LEDG  = 32'hF0000008,
  parameter logic [DBITS-1:0] ADDR_KEY   = 32'hF0000010,
  parameter logic [DBITS-1:0] ADDR_SW    = 32'hF0000014,
  parameter logic [DBITS-1:0] ADDR_KCTRL = 32'hF0000110,
  parameter logic [DBITS-1:0] ADDR_SCTRL = 32'hF0000114,
  parameter int               DEB_CYCLES = 50000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [DBITS-1:0] addr,
  input  logic             wrtEn,
  input  logic             rdEn,
  input  logic [DBITS-1:0] dIn,
  input  logic [3:0]       key,
  input  logic [9:0]       sw,
  output logic [DBITS-1:0] dOut,
  output logic             isIO,
  output logic [15:0]      hex,
  output logic [9:0]       ledr,
  output logic [7:0]       ledg
);
  logic hitHex, hitLedr, hitLedg, hitKey;
  logic hitSw, hitKctrl, hitSctrl;
  logic [3:0] keyDeb;
  logic [9:0] swDeb;
  logic keyRdy, keyOv, swRdy, swOv;
  logic unusedBits;

  assign hitHex   = addr == ADDR_HEX;
  assign hitLedr  = addr == ADDR_LEDR;
  assign hitLedg  = addr == ADDR_LEDG;
  assign hitKey   = addr == ADDR_KEY;
  assign hitSw    = addr == ADDR_SW;
  assign hitKctrl = addr == ADDR_KCTRL;
  assign hitSctrl = addr == ADDR_SCTRL;

  assign isIO = hitHex | hitLedr | hitLedg | hitKey
              | hitSw | hitKctrl | hitSctrl;

  assign unusedBits = ^dIn[DBITS-1:16];

  // KEY is active-low on the board; invert so 1 means pressed
  mmio_debounce #(.W(4), .DEB_CYCLES(DEB_CYCLES)) keyDebU (
    .clk      (clk),
    .reset    (reset),
    .raw      (~key),
    .rdClr    (rdEn && hitKey),
    .wrClrRdy (wrtEn && hitKctrl && !dIn[0]),
    .wrClrOv  (wrtEn && hitKctrl && !dIn[2]),
    .deb      (keyDeb),
    .ready    (keyRdy),
    .overrun  (keyOv)
  );

  mmio_debounce #(.W(10), .DEB_CYCLES(DEB_CYCLES)) swDebU (
    .clk      (clk),
    .reset    (reset),
    .raw      (sw),
    .rdClr    (rdEn && hitSw),
    .wrClrRdy (wrtEn && hitSctrl && !dIn[0]),
    .wrClrOv  (wrtEn && hitSctrl && !dIn[2]),
    .deb      (swDeb),
    .ready    (swRdy),
    .overrun  (swOv)
  );

  // output registers, written by stores
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hex  <= '0;
      ledr <= '0;
      ledg <= '0;
    end else if (wrtEn) begin
      if (hitHex)
        hex <= dIn[15:0];
      if (hitLedr)
        ledr <= dIn[9:0];
      if (hitLedg)
        ledg <= dIn[7:0];
    end
  end

  // combinational read mux, zero-extended
  always_comb begin
    dOut = '0;
    unique case (1'b1)
      hitHex:   dOut = DBITS'(hex);
      hitLedr:  dOut = DBITS'(ledr);
      hitLedg:  dOut = DBITS'(ledg);
      hitKey:   dOut = DBITS'(keyDeb);
      hitSw:    dOut = DBITS'(swDeb);
      hitKctrl: dOut = DBITS'({keyOv, 1'b0, keyRdy});
      hitSctrl: dOut = DBITS'({swOv, 1'b0, swRdy});
      default:  dOut = '0;
    endcase
  end
endmodule

// File: tb/tb_mmio_controller.sv
// tb_mmio_controller: directed and randomized checks of mmio_controller
// against a sliding-window behavioural model.
module tb_mmio_controller;
  localparam logic [31:0] A_HEX   = 32'hF0000000;
  localparam logic [31:0] A_LEDR  = 32'hF0000004;
  localparam logic [31:0] A_LEDG  = 32'hF0000008;
  localparam logic [31:0] A_KEY   = 32'hF0000010;
  localparam logic [31:0] A_SW    = 32'hF0000014;
  localparam logic [31:0] A_KCTRL = 32'hF0000110;
  localparam logic [31:0] A_SCTRL = 32'hF0000114;
  localparam int DEB = 4;

  logic clk = 0;
  logic reset;
  logic [31:0] addr, dIn, dOut;
  logic wrtEn, rdEn, isIO;
  logic [3:0] key;
  logic [9:0] sw;
  logic [15:0] hex;
  logic [9:0] ledr;
  logic [7:0] ledg;

  int checks = 0;
  int failures = 0;
  bit chkOn = 0;

  mmio_controller #(.DEB_CYCLES(DEB)) dut (
    .clk   (clk),
    .reset (reset),
    .addr  (addr),
    .wrtEn (wrtEn),
    .rdEn  (rdEn),
    .dIn   (dIn),
    .key   (key),
    .sw    (sw),
    .dOut  (dOut),
    .isIO  (isIO),
    .hex   (hex),
    .ledr  (ledr),
    .ledg  (ledg)
  );

  always #10 clk = ~clk;

  // model: hist[g][0] is the newest raw sample taken at an edge
  logic [9:0] hist [2][DEB+2];
  logic [9:0] mDeb [2];
  bit mRdy [2];
  bit mOv [2];
  logic [15:0] mHex = 0;
  logic [9:0] mLedr = 0;
  logic [7:0] mLedg = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] expRead(input logic [31:0] a);
    case (a)
      A_HEX:   return {16'b0, mHex};
      A_LEDR:  return {22'b0, mLedr};
      A_LEDG:  return {24'b0, mLedg};
      A_KEY:   return {28'b0, mDeb[0][3:0]};
      A_SW:    return {22'b0, mDeb[1]};
      A_KCTRL: return {29'b0, mOv[0], 1'b0, mRdy[0]};
      A_SCTRL: return {29'b0, mOv[1], 1'b0, mRdy[1]};
      default: return 32'b0;
    endcase
  endfunction

  function automatic bit expIo(input logic [31:0] a);
    return a inside {A_HEX, A_LEDR, A_LEDG, A_KEY,
                     A_SW, A_KCTRL, A_SCTRL};
  endfunction

  // A group's debounced value changes when the DEB+1 samples
  // ending two edges back all agree and differ from it.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int g = 0; g < 2; g++) begin
        for (int i = 0; i < DEB + 2; i++) hist[g][i] = '0;
        mDeb[g] = '0;
        mRdy[g] = 0;
        mOv[g] = 0;
      end
      mHex = 0;
      mLedr = 0;
      mLedg = 0;
    end else begin
      for (int g = 0; g < 2; g++) begin
        bit up, clrR, clrO;
        logic [31:0] dA, cA;
        dA = g ? A_SW : A_KEY;
        cA = g ? A_SCTRL : A_KCTRL;
        up = 1;
        for (int i = 2; i < DEB + 2; i++)
          if (hist[g][i] != hist[g][1]) up = 0;
        if (hist[g][1] == mDeb[g]) up = 0;
        clrR = (rdEn && addr == dA) ||
               (wrtEn && addr == cA && !dIn[0]);
        clrO = wrtEn && addr == cA && !dIn[2];
        if (up) begin
          mOv[g] = mOv[g] | mRdy[g];
          mRdy[g] = 1;
          mDeb[g] = hist[g][1];
        end else begin
          if (clrR) mRdy[g] = 0;
          if (clrO) mOv[g] = 0;
        end
        for (int i = DEB + 1; i > 0; i--) hist[g][i] = hist[g][i-1];
        hist[g][0] = g ? sw : {6'b0, ~key};
      end
      if (wrtEn) begin
        if (addr == A_HEX) mHex = dIn[15:0];
        if (addr == A_LEDR) mLedr = dIn[9:0];
        if (addr == A_LEDG) mLedg = dIn[7:0];
      end
    end
  end

  // per-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    if (chkOn) begin
      chk("dOut", dOut, expRead(addr));
      chk("isIO", {31'b0, isIO}, {31'b0, expIo(addr)});
      chk("hex", {16'b0, hex}, {16'b0, mHex});
      chk("ledr", {22'b0, ledr}, {22'b0, mLedr});
      chk("ledg", {24'b0, ledg}, {24'b0, mLedg});
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    addr = a;
    dIn = d;
    wrtEn = 1;
    rdEn = 0;
    cyc(1);
    wrtEn = 0;
  endtask

  task automatic load(input logic [31:0] a);
    addr = a;
    rdEn = 1;
    cyc(1);
    rdEn = 0;
  endtask

  task automatic peek(input string nm, input logic [31:0] a,
                      input logic [31:0] exp);
    addr = a;
    #1;
    chk(nm, dOut, exp);
  endtask

  task automatic peekIo(input string nm, input logic [31:0] a,
                        input bit io, input logic [31:0] exp);
    addr = a;
    #1;
    chk({nm, "_io"}, {31'b0, isIO}, {31'b0, io});
    chk(nm, dOut, exp);
  endtask

  initial begin
    int sel, b;
    reset = 0;
    key = 4'hF;
    sw = '0;
    addr = '0;
    dIn = '0;
    wrtEn = 0;
    rdEn = 0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1;
    chkOn = 1;
    cyc(1);

    chk("rst_hex", {16'b0, hex}, 32'h0);
    chk("rst_ledr", {22'b0, ledr}, 32'h0);
    chk("rst_ledg", {24'b0, ledg}, 32'h0);
    peek("rst_kctrl", A_KCTRL, 32'h0);

    store(A_HEX, 32'h0000ABCD);
    store(A_LEDR, 32'h000003FF);
    store(A_LEDG, 32'h0000005A);
    chk("wr_hex", {16'b0, hex}, 32'hABCD);
    chk("wr_ledr", {22'b0, ledr}, 32'h3FF);
    chk("wr_ledg", {24'b0, ledg}, 32'h5A);
    store(A_KEY, 32'hFFFFFFFF);
    chk("ro_hex", {16'b0, hex}, 32'hABCD);
    chk("ro_ledr", {22'b0, ledr}, 32'h3FF);
    chk("ro_ledg", {24'b0, ledg}, 32'h5A);
    peek("ro_key", A_KEY, 32'h0);

    peekIo("dec_unal", 32'hF0000012, 0, 32'h0);
    peekIo("dec_low", 32'h00000010, 0, 32'h0);
    peekIo("dec_ledg", A_LEDG, 1, 32'h5A);

    key = 4'b1101;
    cyc(6);
    peek("deb_early", A_KEY, 32'h0);
    cyc(1);
    peek("deb_key", A_KEY, 32'h2);
    peek("deb_kctrl", A_KCTRL, 32'h1);
    load(A_KEY);
    peek("deb_rdclr", A_KCTRL, 32'h0);
    key = 4'hF;
    cyc(8);
    store(A_KCTRL, 32'h0);
    peek("deb_rel", A_KEY, 32'h0);

    key = 4'b1011;
    cyc(3);
    key = 4'hF;
    cyc(10);
    peek("pulse_key", A_KEY, 32'h0);
    peek("pulse_kctrl", A_KCTRL, 32'h0);

    sw = 10'h001;
    cyc(8);
    sw = 10'h003;
    cyc(8);
    peek("ov_sw", A_SW, 32'h3);
    peek("ov_sctrl", A_SCTRL, 32'h5);
    load(A_SW);
    peek("ov_rd", A_SCTRL, 32'h4);
    store(A_SCTRL, 32'h0);
    peek("ov_wr", A_SCTRL, 32'h0);

    key = 4'b0111;
    cyc(8);
    peek("col_pre", A_KCTRL, 32'h1);
    key = 4'b0110;
    cyc(6);
    addr = A_KEY;
    rdEn = 1;
    cyc(1);
    rdEn = 0;
    peek("col_rdy1", A_KCTRL, 32'h5);
    peek("col_key1", A_KEY, 32'h9);
    store(A_KCTRL, 32'h0);
    peek("col_clr", A_KCTRL, 32'h0);
    key = 4'b0111;
    cyc(6);
    addr = A_KEY;
    rdEn = 1;
    cyc(1);
    rdEn = 0;
    peek("col_rdy0", A_KCTRL, 32'h1);
    peek("col_key0", A_KEY, 32'h8);

    store(A_LEDR, 32'h3FF);
    sw = 10'h023;
    cyc(3);
    #3;
    reset = 0;
    #1;
    chk("rst_ledr_now", {22'b0, ledr}, 32'h0);
    peek("rst_sw_now", A_SW, 32'h0);
    peek("rst_sctrl_now", A_SCTRL, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1;
    cyc(6);
    peek("rel_early", A_SW, 32'h0);
    cyc(1);
    peek("rel_sw", A_SW, 32'h23);
    peek("rel_sctrl", A_SCTRL, 32'h1);

    for (int n = 0; n < 2000; n++) begin
      sel = $urandom_range(0, 9);
      case (sel)
        0: addr = A_HEX;
        1: addr = A_LEDR;
        2: addr = A_LEDG;
        3: addr = A_KEY;
        4: addr = A_SW;
        5: addr = A_KCTRL;
        6: addr = A_SCTRL;
        7: addr = $urandom;
        8: addr = A_KEY + 32'h2;
        default: addr = A_SCTRL ^ (32'h1 << $urandom_range(4, 31));
      endcase
      wrtEn = ($urandom_range(0, 2) == 0);
      rdEn = $urandom_range(0, 1) == 1;
      dIn = $urandom;
      if ($urandom_range(0, 9) == 0) begin
        b = $urandom_range(0, 3);
        key[b] = ~key[b];
      end
      if ($urandom_range(0, 9) == 0) begin
        b = $urandom_range(0, 9);
        sw[b] = ~sw[b];
      end
      cyc(1);
    end
    wrtEn = 0;
    rdEn = 0;
    cyc(2);
    chkOn = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
